addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_chunk.sv | 24 ++
 rtl/addsub_seq.sv | 163 ++++++++++++++++
 tb/tb_addsub_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the chunked add/subtract unit.
// Top: addsub_seq; optional saturation enabled by macro ADDSUB_SAT_EN.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry into and out of its MSB.
// Used once by addsub_seq; the carry into the MSB feeds overflow detection.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum  = full[CHUNK-1:0];
    cout = full[CHUNK];
    // sum_msb = a ^ b ^ carry_in, so the carry in falls out directly
    cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's complement add/subtract, CHUNK bits per clock.
// Define ADDSUB_SAT_EN to add the sat input (signed saturation on overflow).
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             v,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  localparam logic [WIDTH-1:0] SAT_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] ans_n;
  logic             sub_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] csum;
  logic             cco;
  logic             cmsb;
  logic             accept;
  logic             last;
  logic             ovf;

`ifdef ADDSUB_SAT_EN
  logic sat_q;
`else
  logic sat_q;
  assign sat_q = 1'b0;
`endif

  assign accept    = (state == IDLE) && in_valid;
  assign last      = (state == BUSY) && (idx == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero      = (ans == '0);
  assign neg       = ans[WIDTH-1];
  assign ovf       = cco ^ cmsb;

  // Select the active chunk; subtraction inverts b and seeds carry = 1
  always_comb begin
    ca = '0;
    cb = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        ca = a_q[k*CHUNK +: CHUNK];
        cb = b_q[k*CHUNK +: CHUNK];
      end
    end
    cb = cb ^ {CHUNK{sub_q}};
  end

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (ca),
    .b    (cb),
    .cin  (carry),
    .sum  (csum),
    .cout (cco),
    .cmsb (cmsb)
  );

  // Saturation replaces the whole word on the DONE entry edge
  always_comb begin
    ans_n = ans;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        ans_n[k*CHUNK +: CHUNK] = csum;
      end
    end
    if (last && sat_q && ovf) begin
      ans_n = csum[CHUNK-1] ? SAT_POS : SAT_NEG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = BUSY;
      BUSY: if (idx == LAST) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      ans   <= '0;
      cout  <= 1'b0;
      v     <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
      carry <= sub;
      idx   <= '0;
    end else if (state == BUSY) begin
      ans   <= ans_n;
      carry <= cco;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout <= cco;
        v    <= ovf;
      end
    end
  end

`ifdef ADDSUB_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= sat;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Directed plus random bench for addsub_seq against a signed-arithmetic model.
// Compile with ADDSUB_SAT_EN to also exercise saturation.
module tb_addsub_seq;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int NC = W / C;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          sat;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ans;
  logic          cout;
  logic          v;
  logic          zero;
  logic          neg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_seq #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
`ifdef ADDSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans),
    .cout      (cout),
    .v         (v),
    .zero      (zero),
    .neg       (neg)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: true signed/unsigned results, not a bit-level adder
  task automatic model(input  logic [W-1:0] x,
                       input  logic [W-1:0] y,
                       input  logic         s,
                       input  logic         st,
                       output logic [W-1:0] r,
                       output logic         co,
                       output logic         ov);
    longint sx;
    longint sy;
    longint res;
    longint unsigned ux;
    longint unsigned uy;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = s ? (sx - sy) : (sx + sy);
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    ov  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    co  = s ? (ux >= uy) : ((ux + uy) >= 64'd4294967296);
    r   = res[W-1:0];
    if (st && ov) r = (res < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic         ts,
                        input logic         tsat,
                        input int           hold);
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    logic         st;
    logic [W-1:0] held;
    int           n;
`ifdef ADDSUB_SAT_EN
    st = tsat;
`else
    st = 1'b0;
`endif
    model(ta, tb, ts, st, er, ec, ev);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("idle_ready", {63'd0, in_ready}, 64'd1);
    a        = ta;
    b        = tb;
    sub      = ts;
    sat      = tsat;
    in_valid = 1'b1;
    tick();
    // keep in_valid high with junk operands: must be ignored
    a   = $urandom;
    b   = $urandom;
    sub = 1'($urandom);
    sat = 1'($urandom);
    check("busy_ready", {63'd0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(NC));
    check("ans", {32'd0, ans}, {32'd0, er});
    check("cout", {63'd0, cout}, {63'd0, ec});
    check("v", {63'd0, v}, {63'd0, ev});
    check("zero", {63'd0, zero}, {63'd0, er == '0});
    check("neg", {63'd0, neg}, {63'd0, er[W-1]});
    held = ans;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_ans", {32'd0, ans}, {32'd0, held});
      check("hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    sat       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_flags", {29'd0, cout, v, zero, 32'd0},
          {29'd0, 3'b001, 32'd0});
    check("rst_ans", {32'd0, ans}, 64'd0);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_oready", {62'd0, out_valid, in_ready}, 64'd1);

    run_op(32'h0000_0021, 32'h0000_0022, 1'b0, 1'b0, 0);
    run_op(32'h336F_B7E5, 32'h336F_B7E5, 1'b1, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 5);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);

    // abort mid-BUSY: no result, state cleared
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    sub      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_idle", {62'd0, out_valid, in_ready}, 64'd1);
    check("abort_ans", {32'd0, ans}, 64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("abort_novalid", 64'(n), 64'd0);
    run_op(32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = {1'b0, {31{ra[0]}}};
      if (i % 4 == 2) rb = {1'b1, 31'($urandom_range(0, 3))};
      run_op(ra, rb, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
